// File: rtl/csa_multi_add_pipe.sv
// rtl/csa_multi_add_pipe.sv - pipelined carry-save multi-operand adder with valid/ready handshake
// Optional feature macro: CSA_MULTI_ADD_SIGNED_EN (two's complement operands, adds out_neg)
module csa_multi_add_pipe #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]          in_ops,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH+$clog2(NUM_OPS)-1:0]  out_sum,
    output logic                              busy
`ifdef CSA_MULTI_ADD_SIGNED_EN
    ,
    output logic                              out_neg
`endif
);

    localparam int OUT_WIDTH = WIDTH + $clog2(NUM_OPS);
    localparam int LEVELS    = (NUM_OPS <= 3) ? 1 :
                               (NUM_OPS == 4) ? 2 :
                               (NUM_OPS <= 6) ? 3 : 4;
    localparam int S         = LEVELS + 1;
    localparam int EXT       = OUT_WIDTH - WIDTH;

    // Number of rows entering CSA level lvl (lvl == LEVELS gives the rows fed to the CPA).
    function automatic int rows_in(input int lvl);
        int n;
        n = NUM_OPS;
        for (int i = 0; i < lvl; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    logic [NUM_OPS-1:0][OUT_WIDTH-1:0] ext_rows;
    logic [S-1:0]                      v_d;
    logic [S-1:0]                      v_q;
    logic [S-1:0]                      adv;
    logic [S-1:0]                      v_in;
    logic [1:0][OUT_WIDTH-1:0]         top_rows;
    logic [OUT_WIDTH-1:0]              sum_d;
    logic [OUT_WIDTH-1:0]              sum_q;

    // Widen every operand to the result width before it enters the tree.
    always_comb begin
        logic [WIDTH-1:0] op;
        op       = '0;
        ext_rows = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            op = in_ops[i*WIDTH +: WIDTH];
`ifdef CSA_MULTI_ADD_SIGNED_EN
            ext_rows[i] = {{EXT{op[WIDTH-1]}}, op};
`else
            ext_rows[i] = {{EXT{1'b0}}, op};
`endif
        end
    end

    // Stall chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv          = '0;
        v_in         = '0;
        v_d          = '0;
        adv[S-1]     = out_ready | ~v_q[S-1];
        for (int k = S - 2; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
        v_in[0] = in_valid;
        for (int k = 1; k < S; k++) begin
            v_in[k] = v_q[k-1];
        end
        for (int k = 0; k < S; k++) begin
            v_d[k] = adv[k] ? v_in[k] : v_q[k];
        end
    end

    // Per-stage valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NI = rows_in(l);
        localparam int NO = rows_in(l + 1);
        localparam int G  = NI / 3;
        localparam int R  = NI % 3;

        logic [NI-1:0][OUT_WIDTH-1:0] src;
        logic [NO-1:0][OUT_WIDTH-1:0] row_d;
        logic [NO-1:0][OUT_WIDTH-1:0] row_q;

        if (l == 0) begin : g_src_in
            assign src = ext_rows;
        end else begin : g_src_prev
            assign src = g_lvl[l-1].row_q;
        end

        // 3:2 compression of row triples; leftover rows pass straight through.
        // Carry is shifted left so its bit 0 is a constant zero (half-adder cell).
        always_comb begin
            row_d = row_q;
            if (adv[l] && v_in[l]) begin
                row_d = '0;
                for (int g = 0; g < G; g++) begin
                    row_d[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
                    row_d[2*g+1] = ((src[3*g] & src[3*g+1]) |
                                    (src[3*g] & src[3*g+2]) |
                                    (src[3*g+1] & src[3*g+2])) << 1;
                end
                for (int j = 0; j < R; j++) begin
                    row_d[2*G+j] = src[3*G+j];
                end
            end
        end

        // Level register; holds its contents when no new data arrives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                row_q <= '0;
            end else begin
                row_q <= row_d;
            end
        end
    end

    assign top_rows = g_lvl[LEVELS-1].row_q;

    // Final carry-propagate add of the two remaining rows, modulo 2^OUT_WIDTH.
    always_comb begin
        sum_d = sum_q;
        if (adv[S-1] && v_in[S-1]) begin
            sum_d = top_rows[0] + top_rows[1];
        end
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[S-1];
    assign out_sum   = sum_q;
    assign busy      = |v_q;
`ifdef CSA_MULTI_ADD_SIGNED_EN
    assign out_neg   = sum_q[OUT_WIDTH-1];
`endif

endmodule

// File: tb/tb_csa_multi_add_pipe.sv
// tb/tb_csa_multi_add_pipe.sv - directed self-checking bench for csa_multi_add_pipe
module tb_csa_multi_add_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0]  in_ops;
    logic [17:0]  out_sum;
    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [127:0] in_ops8;
    logic [18:0]  out_sum8;
`ifdef CSA_MULTI_ADD_SIGNED_EN
    logic         out_neg, out_neg8;
`endif

    int checks = 0;
    int failures = 0;
    int k, inflight, got, lat;
    logic saw_block;
    int exp_q[$];

    always #5 clk = ~clk;

    csa_multi_add_pipe #(.WIDTH(16), .NUM_OPS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
`ifdef CSA_MULTI_ADD_SIGNED_EN
        , .out_neg(out_neg)
`endif
    );

    csa_multi_add_pipe #(.WIDTH(16), .NUM_OPS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_ops(in_ops8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .busy(busy8)
`ifdef CSA_MULTI_ADD_SIGNED_EN
        , .out_neg(out_neg8)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] x);
        return {x, x, x, x};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; in_ops = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; in_ops8 = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
`ifdef CSA_MULTI_ADD_SIGNED_EN
        chk("rst_out_neg", 64'(out_neg), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic sum with latency check.
        in_ops = {16'd4, 16'd3, 16'd2, 16'd1};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("basic_lat1", 64'(out_valid), 64'd0);
        tick;
        chk("basic_lat2", 64'(out_valid), 64'd0);
        tick;
        chk("basic_lat3", 64'(out_valid), 64'd1);
        chk("basic_sum", 64'(out_sum), 64'd10);
        tick;
        chk("basic_drain", 64'(out_valid), 64'd0);
        chk("basic_busy", 64'(busy), 64'd0);

        // Max values, four operands.
        in_ops = {4{16'hFFFF}};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("max4_valid", 64'(out_valid), 64'd1);
        chk("max4_sum", 64'(out_sum), 64'h3FFFC);
        tick;

        // Max values, eight operands.
        in_ops8 = {8{16'hFFFF}};
        in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 12) begin
            tick;
            lat++;
        end
        chk("max8_latency", 64'(lat), 64'd5);
        chk("max8_valid", 64'(out_valid8), 64'd1);
        chk("max8_sum", 64'(out_sum8), 64'h7FFF8);
        tick;

        // Back-pressure streaming with an in-order scoreboard.
        k = 1; inflight = 0; got = 0; saw_block = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 10);
            in_valid = (k <= 6);
            in_ops = rep4(k[15:0]);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(out_ready || inflight < 3));
            if (!in_ready) saw_block = 1'b1;
            if (out_valid) begin
                if (exp_q.size() > 0) chk("bp_sum", 64'(out_sum), 64'(exp_q[0]));
                else chk("bp_spurious", 64'(out_valid), 64'd0);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                got++;
                inflight--;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(4 * k);
                k++;
                inflight++;
            end
            tick;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(got), 64'd6);
        chk("bp_blocked", 64'(saw_block), 64'd1);
        chk("bp_left", 64'(exp_q.size()), 64'd0);
        chk("bp_busy", 64'(busy), 64'd0);

        // Bubble collapse under a stalled output.
        out_ready = 1'b0;
        in_ops = rep4(16'd7);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        in_ops = rep4(16'd2);
        in_valid = 1'b1;
        chk("bub_ready_b", 64'(in_ready), 64'd1);
        tick;
        in_valid = 1'b0;
        chk("bub_ready_1", 64'(in_ready), 64'd1);
        tick;
        chk("bub_valid", 64'(out_valid), 64'd1);
        chk("bub_sum_a", 64'(out_sum), 64'd28);
        chk("bub_ready_2", 64'(in_ready), 64'd1);
        in_ops = rep4(16'd1);
        in_valid = 1'b1;
        tick;
        in_ops = rep4(16'd9);
        chk("bub_full", 64'(in_ready), 64'd0);
        tick;
        chk("bub_hold", 64'(out_sum), 64'd28);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("bub_sum_b", 64'(out_sum), 64'd8);
        tick;
        chk("bub_sum_c", 64'(out_sum), 64'd4);
        chk("bub_valid_c", 64'(out_valid), 64'd1);
        tick;
        chk("bub_empty", 64'(out_valid), 64'd0);
        chk("bub_busy", 64'(busy), 64'd0);

        // Asynchronous reset with three bundles in flight.
        out_ready = 1'b0;
        in_ops = rep4(16'd3);
        in_valid = 1'b1;
        tick;
        tick;
        tick;
        in_valid = 1'b0;
        chk("rmid_busy_pre", 64'(busy), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", 64'(out_valid), 64'd0);
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_out_sum", 64'(out_sum), 64'd0);
        #2;
        rst_n = 1'b1;
        tick;
        chk("rmid_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rmid_stale", 64'(out_valid), 64'd0);
            tick;
        end
        in_ops = rep4(16'd5);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("rmid_new_valid", 64'(out_valid), 64'd1);
        chk("rmid_new_sum", 64'(out_sum), 64'd20);
        tick;

`ifdef CSA_MULTI_ADD_SIGNED_EN
        // Signed operands.
        in_ops = {16'd0, 16'd3, 16'hFFFE, 16'hFFFF};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("sgn_zero_sum", 64'(out_sum), 64'h00000);
        chk("sgn_zero_neg", 64'(out_neg), 64'd0);
        tick;
        in_ops = {4{16'h8000}};
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk("sgn_min_sum", 64'(out_sum), 64'h20000);
        chk("sgn_min_neg", 64'(out_neg), 64'd1);
        tick;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csa_multi_add_pipe.md
Name: csa_multi_add_pipe

Overview:
- Pipelined multi-operand adder. Sums NUM_OPS operands of WIDTH bits each through a registered carry-save (3:2 compressor) tree, then a registered carry-propagate stage.
- Output is full precision; no overflow is possible.
- Sits in datapath blocks (MAC, filter, checksum) that synthesise through the platform's full-adder/half-adder mapping.
- Valid/ready handshake on both sides. Per-stage valid bits collapse bubbles.

Parameters:
- WIDTH, 16, bit width of each input operand (2..64).
- NUM_OPS, 4, number of operands per transaction (3..8).
- OUT_WIDTH (localparam), WIDTH+$clog2(NUM_OPS), result width.
- LEVELS (localparam), CSA tree depth: NUM_OPS 3→1, 4→2, 5..6→3, 7..8→4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_ops  in  NUM_OPS*WIDTH  operand i at [i*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  OUT_WIDTH  sum of the accepted bundle.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Stages: LEVELS CSA stages, then 1 CPA stage. Total stages S = LEVELS+1. Every stage is registered.
- Latency: S cycles from accept to out_valid with no stalls (NUM_OPS=4 gives 3 cycles).
- Operand extension: each operand is zero-extended to OUT_WIDTH before the tree.
- CSA levels: each level groups rows in threes into 3:2 compressors.
  - A 3:2 compressor outputs sum = a^b^c and carry = maj(a,b,c)<<1.
  - Leftover rows (1 or 2) pass through registered, unchanged.
  - Carry LSB is constant 0, so the bit-0 cell reduces to a half adder.
- Final CSA output is exactly 2 rows. The CPA adds them modulo 2^OUT_WIDTH.
- Handshake: each stage k has a valid bit v[k].
  - Stage S-1 advances when out_ready | ~v[S-1].
  - Stage k<S-1 advances when ~v[k] | (stage k+1 advances).
  - in_ready = stage 0 advances. Transfer occurs when in_valid & in_ready.
- Data registers load only on advance. When a stage advances without incoming data, its valid clears and its data is held (no X propagation).
- out_valid = v[S-1]; out_sum = CPA register.
  - out_sum holds stable while out_valid & ~out_ready.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to any output.
- Full pipeline with out_ready=0: in_ready=0, all state frozen.
- Simultaneous accept and emit at full occupancy: allowed. Throughput is 1 result/cycle.
- Bubbles: an empty stage accepts even if downstream is stalled.
- busy = OR of all v[k].
- Reset (any time, including mid-operation): all v[k]=0, out_valid=0, busy=0, out_sum=0, all data registers 0, in_ready=1 after reset deasserts. In-flight bundles are dropped.

Optional Feature:
- Macro: CSA_MULTI_ADD_SIGNED_EN.
- Defined:
  - Operands are two's complement and sign-extended to OUT_WIDTH.
  - out_sum is the signed sum, in two's complement.
  - An extra output out_neg (1 bit) equals out_sum[OUT_WIDTH-1]. It resets to 0 and holds with out_sum.
- Undefined: operands are unsigned and zero-extended. out_neg does not exist.

Test Plan:
- Basic sum: WIDTH=16, NUM_OPS=4, ops {1,2,3,4}, out_ready=1 → out_sum=10, out_valid exactly 3 cycles after accept.
- Max values: ops all 16'hFFFF, NUM_OPS=4 → out_sum=18'h3FFFC. Repeat with NUM_OPS=8 → out_sum=19'h7FFF8.
- Back-pressure: stream 6 bundles {k,k,k,k} for k=1..6, hold out_ready=0 from cycle 2 to cycle 10, then release. Required:
  - in_ready drops after 3 bundles are in flight.
  - out_sum holds 4 while stalled.
  - Results 4,8,12,16,20,24 emerge in order, with no loss or duplication.
- Bubble collapse: single bundle, then idle 2 cycles, then bundle, with out_ready=0 → both bundles pack into the last two stages. in_ready stays 1 until 3 bundles are held.
- Reset mid-flight: assert rst_n=0 asynchronously, between clock edges, while 3 bundles are in flight → out_valid=0, busy=0, out_sum=0 immediately. After release, no stale result appears and a new bundle {5,5,5,5} yields 20.
- Signed (CSA_MULTI_ADD_SIGNED_EN): ops {16'hFFFF,16'hFFFE,3,0} → out_sum=18'h00000, out_neg=0. Ops {16'h8000 ×4} → out_sum=18'h20000, out_neg=1.
